// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: mode encodings and count-width helper shared by univ_shift_reg and usr_cell
package univ_shift_reg_pkg;
   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction
endpackage

// File: rtl/usr_cell.sv
// usr_cell: one register bit with a 4:1 next-state mux and an enable-gated flop (async reset, sync preset)
module usr_cell import univ_shift_reg_pkg::*; #(
   parameter logic RST_VAL = 1'b0,
   parameter logic PRE_VAL = 1'b1
) (
   input  logic       clock,
   input  logic       _reset,
   input  logic       _preset,
   input  logic       e,
   input  logic [1:0] mode,
   input  logic       from_hi,
   input  logic       from_lo,
   input  logic       d,
   output logic       q
);
   logic nxt;
   // next-state select: hold, higher neighbour, lower neighbour or parallel data
   always_comb nxt = mode == MODE_HOLD ? q : mode == MODE_SHR ? from_hi : mode == MODE_SHL ? from_lo : d;
   // storage bit: reset dominates preset, preset dominates enable
   always_ff @(posedge clock or negedge _reset)
      if (!_reset) q <= RST_VAL;
      else if (!_preset) q <= PRE_VAL;
      else if (e) q <= nxt;
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register; UNIV_SHIFT_REG_SHIFT_COUNT_EN adds a saturating shift counter (cnt, full)
module univ_shift_reg import univ_shift_reg_pkg::*; #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
   input  logic             clock,
   input  logic             _reset,
   input  logic             _preset,
   input  logic             e,
   input  logic [1:0]       mode,
   input  logic             rot,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] nq,
   output logic             sout_r,
   output logic             sout_l
`ifdef UNIV_SHIFT_REG_SHIFT_COUNT_EN
   ,
   output logic [cnt_width(WIDTH)-1:0] cnt,
   output logic                        full
`endif
);
   logic [WIDTH-1:0] from_hi, from_lo;
   // neighbour feeds for each cell; end bits take the serial input or the wrapped bit
   always_comb begin
      from_hi = {rot ? q[0] : sin_r, q[WIDTH-1:1]};
      from_lo = {q[WIDTH-2:0], rot ? q[WIDTH-1] : sin_l};
   end
   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_cell
         usr_cell #(.RST_VAL(RESET_VAL[i]), .PRE_VAL(PRESET_VAL[i])) u_cell (
            .clock(clock), ._reset(_reset), ._preset(_preset), .e(e), .mode(mode),
            .from_hi(from_hi[i]), .from_lo(from_lo[i]), .d(d[i]), .q(q[i])
         );
      end
   endgenerate
   assign nq     = ~q;
   assign sout_r = q[0];
   assign sout_l = q[WIDTH-1];
`ifdef UNIV_SHIFT_REG_SHIFT_COUNT_EN
   localparam int CW = cnt_width(WIDTH);
   // shift counter: cleared by reset, preset or load; counts enabled shifts up to WIDTH
   always_ff @(posedge clock or negedge _reset)
      if (!_reset) cnt <= '0;
      else if (!_preset) cnt <= '0;
      else if (e && mode == MODE_LOAD) cnt <= '0;
      else if (e && (mode == MODE_SHR || mode == MODE_SHL) && cnt != CW'(WIDTH)) cnt <= cnt + CW'(1);
   assign full = cnt == CW'(WIDTH);
`endif
endmodule
